// File: rtl/aes_ctrl_defs_pkg.sv
// aes_ctrl_defs
// Shared definitions for the AES request arbiter slice: run/drain FSM state
// encodings and the default block width.
package aes_ctrl_defs;

    localparam int DATA_W_DEFAULT = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_e;

endpackage : aes_ctrl_defs

// File: rtl/aes_tag_fifo.sv
// aes_tag_fifo
// In-order tag FIFO: remembers which requester owns each block in flight.
// Ports:
//   clock, resetn   : system clock, async active-low reset
//   push, push_data : write a tag (ignored when full)
//   pop             : drop the head tag (ignored when empty)
//   head            : oldest tag, valid only when empty=0
//   full, empty     : occupancy flags
//   count           : number of tags stored (0..DEPTH)
module aes_tag_fifo #(
    parameter  int WIDTH = 2,
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule : aes_tag_fifo

// File: rtl/aes_req_arbiter.sv
// aes_req_arbiter
// Shares one pipelined AES encryption core between NUM_REQ requesters.
// A round-robin arbiter issues blocks into the core; a tag FIFO records the
// owner of every block in flight so each ciphertext is routed back to the
// requester that sent it. A run/drain FSM pulses the core start and lets
// traffic quiesce before going idle.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | stopped, waiting for en=1
// ST_START | one-cycle core_start pulse
// ST_RUN   | issuing blocks, returning responses
// ST_DRAIN | no new issue; wait for all in-flight blocks to return
//
// Ports:
//   clock, resetn                 : system clock, async active-low reset
//   en                            : 1 = run, 0 = stop after draining
//   req_valid/req_data/req_ready  : requester issue side (data flattened)
//   rsp_valid/rsp_data/rsp_ready  : requester response side
//   core_start                    : start pulse to the core
//   core_in_*/core_out_*          : core input/output handshakes
//   busy                          : FSM not idle
//   outstanding                   : blocks in flight
//   err_orphan                    : sticky, core output seen with no tag
module aes_req_arbiter
    import aes_ctrl_defs::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int DATA_W    = DATA_W_DEFAULT,
    parameter  int TAG_DEPTH = 16,
    localparam int ID_W      = $clog2(NUM_REQ),
    localparam int CNT_W     = $clog2(TAG_DEPTH) + 1
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      en,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic                      core_start,
    output logic [DATA_W-1:0]         core_in_data,
    output logic                      core_in_valid,
    input  logic                      core_in_ready,
    input  logic [DATA_W-1:0]         core_out_data,
    input  logic                      core_out_valid,
    output logic                      core_out_ready,
    output logic                      busy,
    output logic [CNT_W-1:0]          outstanding,
    output logic                      err_orphan
);

    arb_state_e       state_q;
    arb_state_e       state_d;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  grant_idx;
    logic             any_valid;
    logic             issue_allowed;
    logic             in_xfer;
    logic             pop;
    logic [ID_W-1:0]  head;
    logic             fifo_full;
    logic             fifo_empty;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (en) state_d = ST_START;
            ST_START: state_d = ST_RUN;
            ST_RUN:   if (!en) state_d = ST_DRAIN;
            ST_DRAIN: begin
                // Re-enabling mid-drain resumes without another start pulse.
                if (en)
                    state_d = ST_RUN;
                else if (outstanding == '0 && !pop)
                    state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        core_start    = (state_q == ST_START);
        busy          = (state_q != ST_IDLE);
        // Full FIFO blocks issue even if a pop lands in the same cycle.
        issue_allowed = (state_q == ST_RUN) && !fifo_full;
    end

    // ---------------- Round-robin grant ----------------
    // Search from rr_ptr upward, wrapping; first valid requester wins.
    always_comb begin
        int  idx;
        logic found;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[idx]) begin
                grant_idx = ID_W'(idx);
                found     = 1'b1;
            end
        end
    end

    assign any_valid     = |req_valid;
    assign core_in_valid = issue_allowed & any_valid;
    assign in_xfer       = core_in_valid & core_in_ready;

    always_comb begin
        core_in_data = '0;
        req_ready    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                core_in_data = req_data[i*DATA_W +: DATA_W];
                req_ready[i] = issue_allowed & core_in_ready & any_valid;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rr_ptr <= '0;
        end else if (in_xfer) begin
            if (grant_idx == ID_W'(NUM_REQ - 1)) rr_ptr <= '0;
            else                                 rr_ptr <= grant_idx + 1'b1;
        end
    end

    // ---------------- Response routing ----------------
    // With no tag in flight the core output is an orphan: accept it so the
    // core cannot stall, and hide it from every requester.
    always_comb begin
        rsp_valid      = '0;
        rsp_data       = core_out_data;
        core_out_ready = 1'b0;
        if (fifo_empty) begin
            core_out_ready = core_out_valid;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (head == ID_W'(i)) begin
                    rsp_valid[i]   = core_out_valid;
                    core_out_ready = rsp_ready[i];
                end
            end
        end
    end

    assign pop = core_out_valid & core_out_ready & ~fifo_empty;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)                         err_orphan <= 1'b0;
        else if (core_out_valid && fifo_empty) err_orphan <= 1'b1;
    end

    aes_tag_fifo #(
        .WIDTH (ID_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clock     (clock),
        .resetn    (resetn),
        .push      (in_xfer),
        .push_data (grant_idx),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (outstanding)
    );

endmodule : aes_req_arbiter
